// File: rtl/load_extract_if.sv
// Request/response bundle for the load extract unit: request side carries the
// memory word plus load decode, response side carries the extended result.
interface load_extract_if;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  opcode;
    logic [1:0]  addr_lo;
    logic [31:0] MemOut;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] load_data;
    logic        misalign;
    logic        illegal;

    modport master (
        output in_valid, opcode, addr_lo, MemOut, out_ready,
        input  in_ready, out_valid, load_data, misalign, illegal
    );

    modport slave (
        input  in_valid, opcode, addr_lo, MemOut, out_ready,
        output in_ready, out_valid, load_data, misalign, illegal
    );
endinterface

// File: rtl/load_extract_unit.sv
// Load lane select and sign/zero extension in front of MEM/WB, buffered by a
// head register plus one skid entry so writeback back-pressure never loses a load.
module load_extract_unit (
    input  logic          Clk,
    input  logic          Reset,
    load_extract_if.slave bus
);
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;

    typedef struct packed {
        logic [31:0] data;
        logic        misalign;
        logic        illegal;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

    function automatic entry_t extract(input logic [5:0] op, input logic [1:0] a,
                                       input logic [31:0] mem);
        entry_t             e;
        logic signed [15:0] half_s;
        logic signed [7:0]  byte_s;
        e      = '0;
        half_s = a[1] ? mem[31:16] : mem[15:0];
        case (a)
            2'd0:    byte_s = mem[7:0];
            2'd1:    byte_s = mem[15:8];
            2'd2:    byte_s = mem[23:16];
            default: byte_s = mem[31:24];
        endcase
        case (op)
            OP_LW: begin
                e.data     = mem;
                e.misalign = (a != 2'b00);
            end
            OP_LH: begin
                e.data     = 32'(half_s);
                e.misalign = a[0];
            end
            OP_LHU: begin
                e.data     = {16'h0000, half_s};
                e.misalign = a[0];
            end
            OP_LB:   e.data    = 32'(byte_s);
            OP_LBU:  e.data    = {24'h000000, byte_s};
            default: e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    state_e state_q, state_d;
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    entry_t new_entry;
    logic   in_ready_w;
    logic   out_valid_w;
    logic   accept;
    logic   drain;

    assign new_entry   = extract(bus.opcode, bus.addr_lo, bus.MemOut);
    // Ready depends only on registered occupancy, never on out_ready.
    assign in_ready_w  = (state_q != FULL);
    assign out_valid_w = (state_q != EMPTY);
    assign accept      = bus.in_valid && in_ready_w;
    assign drain       = out_valid_w && bus.out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    head_d  = new_entry;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    head_d = new_entry;
                end else if (accept) begin
                    skid_d  = new_entry;
                    state_d = FULL;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (drain) begin
                    head_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= EMPTY;
            head_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.load_data = head_q.data;
    assign bus.misalign  = head_q.misalign;
    assign bus.illegal   = head_q.illegal;
endmodule

// File: tb/tb_load_extract_unit.sv
// Bench for load_extract_unit: directed plan cases plus randomized traffic,
// all scored against a queue-based reference of the 2-deep buffer.
module tb_load_extract_unit;
    logic Clk;
    logic Reset;
    int   n_checks;
    int   n_errors;

    load_extract_if bus ();

    load_extract_unit dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] d;
        logic        m;
        logic        i;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s got %h want %h", tag, obs, expv);
        end
    endtask

    function automatic exp_t ref_load(input logic [5:0] op, input logic [1:0] a,
                                      input logic [31:0] mem);
        exp_t        e;
        int unsigned v;
        e.d = 0;
        e.m = 0;
        e.i = 0;
        case (op)
            6'b100011: begin
                e.d = mem;
                e.m = (a != 0);
            end
            6'b100001, 6'b100101: begin
                v = (mem >> (16 * (a / 2))) & 32'hFFFF;
                if (op == 6'b100001 && v >= 32768) v = v - 65536;
                e.d = v;
                e.m = (a % 2 == 1);
            end
            6'b100000, 6'b100100: begin
                v = (mem >> (8 * a)) & 32'hFF;
                if (op == 6'b100000 && v >= 128) v = v - 256;
                e.d = v;
            end
            default: e.i = 1;
        endcase
        return e;
    endfunction

    task automatic drive(input logic v, input logic [5:0] op, input logic [1:0] a,
                         input logic [31:0] mem, input logic rdy);
        bus.in_valid  = v;
        bus.opcode    = op;
        bus.addr_lo   = a;
        bus.MemOut    = mem;
        bus.out_ready = rdy;
    endtask

    // One clock: score outputs at the falling edge, advance the model, then
    // return just after the rising edge so the caller can set new inputs.
    task automatic cycle();
        int  sz;
        bit  take;
        @(negedge Clk);
        sz = q.size();
        chk("out_valid", 32'(bus.out_valid), 32'(sz > 0));
        chk("in_ready", 32'(bus.in_ready), 32'(sz < 2));
        if (sz > 0) begin
            chk("load_data", bus.load_data, q[0].d);
            chk("misalign", 32'(bus.misalign), 32'(q[0].m));
            chk("illegal", 32'(bus.illegal), 32'(q[0].i));
        end
        if (Reset) begin
            q.delete();
        end else begin
            take = bus.in_valid && (sz < 2);
            if (sz > 0 && bus.out_ready) void'(q.pop_front());
            if (take) q.push_back(ref_load(bus.opcode, bus.addr_lo, bus.MemOut));
        end
        @(posedge Clk);
        #1;
    endtask

    logic [5:0]  t_op  [8] = '{6'b100000, 6'b100100, 6'b100000, 6'b100001,
                               6'b100101, 6'b100011, 6'b100001, 6'b101011};
    logic [1:0]  t_a   [8] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd0};
    logic [31:0] t_exp [8] = '{32'hFFFFFF82, 32'h00000082, 32'h0000007F, 32'hFFFF80F1,
                               32'h000080F1, 32'h80F17F82, 32'hFFFF80F1, 32'h00000000};
    logic        t_mis [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        t_ill [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [5:0]  legal [5] = '{6'b100011, 6'b100001, 6'b100101, 6'b100000, 6'b100100};

    initial begin
        n_checks = 0;
        n_errors = 0;
        Reset    = 1'b1;
        drive(1'b0, 6'b0, 2'b0, 32'h0, 1'b0);
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;

        // Reset then idle
        @(negedge Clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_load_data", bus.load_data, 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge Clk);
        #1;
        cycle();

        // Extension, misalign and illegal table with one-cycle latency
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, t_op[k], t_a[k], 32'h80F17F82, 1'b1);
            cycle();
            drive(1'b0, 6'b0, 2'b0, 32'h0, 1'b1);
            chk("tbl_valid", 32'(bus.out_valid), 32'd1);
            chk("tbl_data", bus.load_data, t_exp[k]);
            chk("tbl_mis", 32'(bus.misalign), 32'(t_mis[k]));
            chk("tbl_ill", 32'(bus.illegal), 32'(t_ill[k]));
            cycle();
        end

        // Back-pressure: two accepted, third held until space frees
        drive(1'b1, 6'b100011, 2'd0, 32'h11111111, 1'b0);
        cycle();
        drive(1'b1, 6'b100011, 2'd0, 32'h22222222, 1'b0);
        cycle();
        drive(1'b1, 6'b100011, 2'd0, 32'h33333333, 1'b0);
        cycle();
        chk("bp_full_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_head", bus.load_data, 32'h11111111);
        cycle();
        bus.out_ready = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        repeat (4) cycle();

        // Streaming: accept and drain together, occupancy stays ONE
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, legal[k % 5], 2'($urandom_range(0, 3)), $urandom, 1'b1);
            cycle();
            chk("stream_ready", 32'(bus.in_ready), 32'd1);
        end
        bus.in_valid = 1'b0;
        cycle();

        // Reset while FULL discards both entries
        drive(1'b1, 6'b100011, 2'd0, 32'hAAAA5555, 1'b0);
        cycle();
        drive(1'b1, 6'b100000, 2'd3, 32'h5555AAAA, 1'b0);
        cycle();
        bus.in_valid = 1'b0;
        Reset = 1'b1;
        cycle();
        Reset = 1'b0;
        bus.out_ready = 1'b1;
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_ready", 32'(bus.in_ready), 32'd1);
        repeat (3) cycle();

        // Randomized traffic with occasional reset
        for (int k = 0; k < 600; k++) begin
            Reset = ($urandom_range(0, 79) == 0);
            drive(1'($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 5) == 0) ? 6'($urandom) : legal[$urandom_range(0, 4)],
                  2'($urandom), $urandom, 1'($urandom_range(0, 2) != 0));
            cycle();
        end
        Reset = 1'b0;
        drive(1'b0, 6'b0, 2'b0, 32'h0, 1'b1);
        repeat (4) cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
